// File: rtl/ram_bus_arbiter_if.sv
// RAM bus bundle: CPU, flash-loader and diagnostics request ports plus the shared RAM port.
// The arbiter uses the master modport; request sources and the RAM model use slave.
interface ram_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_cs;
    logic              cpu_we;
    logic [ADDR_W-1:0] fl_addr;
    logic [DATA_W-1:0] fl_din;
    logic              fl_cs;
    logic              fl_we;
    logic [ADDR_W-1:0] dg_addr;
    logic [DATA_W-1:0] dg_din;
    logic              dg_cs;
    logic              dg_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_cs;
    logic              ram_we;

    modport master (
        input  cpu_addr, cpu_din, cpu_cs, cpu_we,
        input  fl_addr, fl_din, fl_cs, fl_we,
        input  dg_addr, dg_din, dg_cs, dg_we,
        output ram_addr, ram_din, ram_cs, ram_we
    );

    modport slave (
        output cpu_addr, cpu_din, cpu_cs, cpu_we,
        output fl_addr, fl_din, fl_cs, fl_we,
        output dg_addr, dg_din, dg_cs, dg_we,
        input  ram_addr, ram_din, ram_cs, ram_we
    );
endinterface

// File: rtl/ram_bus_arbiter.sv
// RAM ownership arbiter (flash loader / CPU / diagnostics) with phi2-aligned CPU halt handshake.
// Optional mirrored write-window decode is built when RAM_BUS_ARBITER_WINDOW_EN is defined.
module ram_bus_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int NUM_WIN   = 4,
    parameter int TIMEOUT_W = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_done,
    input  logic                      halt_req,
    input  logic                      phi2,
    input  logic                      rwbar,
    ram_bus_arbiter_if.master         bus,
    input  logic [NUM_WIN*ADDR_W-1:0] win_start,
    input  logic [NUM_WIN*ADDR_W-1:0] win_end,
    output logic                      rdy,
    output logic                      halt_ack,
    output logic                      halt_err,
    output logic [1:0]                owner,
    output logic [NUM_WIN-1:0]        win_we,
    output logic [ADDR_W-1:0]         win_off
);
    // state     | meaning
    // LOAD      | flash loader owns RAM, CPU held off
    // RUN       | CPU owns RAM
    // HALT_WAIT | RDY low, CPU keeps RAM until a full read-only phi2 phase ends
    // HALTED    | diagnostics owns RAM
    // RESUME    | one clk handback to CPU before RUN
    typedef enum logic [2:0] {S_LOAD, S_RUN, S_HALT_WAIT, S_HALTED, S_RESUME} state_t;

    localparam logic [1:0] OWN_FLASH = 2'd0;
    localparam logic [1:0] OWN_CPU   = 2'd1;
    localparam logic [1:0] OWN_DIAG  = 2'd2;

    state_t               state, state_nxt;
    logic [TIMEOUT_W-1:0] tmr, tmr_nxt, tmr_inc;
    logic                 err_set, rdy_nxt, halt_ack_nxt;
    logic [1:0]           owner_nxt;
    logic                 phi2_s1, phi2_s2, phi2_d, rwbar_s1, rwbar_s2, rw_ok, phi2f;

    // rwbar shares the phi2 synchroniser delay so both are sampled on the same clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phi2_s1  <= 1'b0;
            phi2_s2  <= 1'b0;
            phi2_d   <= 1'b0;
            rwbar_s1 <= 1'b0;
            rwbar_s2 <= 1'b0;
            rw_ok    <= 1'b0;
        end else begin
            phi2_s1  <= phi2;
            phi2_s2  <= phi2_s1;
            phi2_d   <= phi2_s2;
            rwbar_s1 <= rwbar;
            rwbar_s2 <= rwbar_s1;
            if (phi2_s2)
                rw_ok <= phi2_d ? (rw_ok & rwbar_s2) : rwbar_s2;
        end
    end

    assign phi2f   = phi2_d & ~phi2_s2;
    assign tmr_inc = tmr + TIMEOUT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_LOAD;
            tmr      <= '0;
            halt_err <= 1'b0;
            rdy      <= 1'b0;
            halt_ack <= 1'b0;
            owner    <= OWN_FLASH;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            halt_err <= halt_err | err_set;
            rdy      <= rdy_nxt;
            halt_ack <= halt_ack_nxt;
            owner    <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tmr_nxt      = '0;
        err_set      = 1'b0;
        rdy_nxt      = 1'b0;
        halt_ack_nxt = 1'b0;
        owner_nxt    = OWN_FLASH;
        case (state)
            S_LOAD:
                if (load_done) state_nxt = S_RUN;
            S_RUN:
                if (!load_done)    state_nxt = S_LOAD;
                else if (halt_req) state_nxt = S_HALT_WAIT;
            S_HALT_WAIT: begin
                tmr_nxt = tmr_inc;
                if (!load_done)          state_nxt = S_LOAD;
                else if (!halt_req)      state_nxt = S_RUN;
                else if (phi2f && rw_ok) state_nxt = S_HALTED;
                else if (&tmr_inc) begin
                    state_nxt = S_HALTED;
                    err_set   = 1'b1;
                end
            end
            S_HALTED:
                if (!load_done)     state_nxt = S_LOAD;
                else if (!halt_req) state_nxt = S_RESUME;
            S_RESUME:
                state_nxt = load_done ? S_RUN : S_LOAD;
            default:
                state_nxt = S_LOAD;
        endcase
        // Outputs are decoded from the next state so they are registered with it.
        case (state_nxt)
            S_RUN, S_RESUME: begin
                owner_nxt = OWN_CPU;
                rdy_nxt   = 1'b1;
            end
            S_HALT_WAIT: owner_nxt = OWN_CPU;
            S_HALTED: begin
                owner_nxt    = OWN_DIAG;
                halt_ack_nxt = 1'b1;
            end
            default: owner_nxt = OWN_FLASH;
        endcase
    end

    always_comb begin
        bus.ram_addr = bus.cpu_addr;
        bus.ram_din  = bus.cpu_din;
        bus.ram_cs   = bus.cpu_cs;
        bus.ram_we   = bus.cpu_we;
        case (owner)
            OWN_FLASH: begin
                bus.ram_addr = bus.fl_addr;
                bus.ram_din  = bus.fl_din;
                bus.ram_cs   = bus.fl_cs;
                bus.ram_we   = bus.fl_we;
            end
            OWN_DIAG: begin
                bus.ram_addr = bus.dg_addr;
                bus.ram_din  = bus.dg_din;
                bus.ram_cs   = bus.dg_cs;
                bus.ram_we   = bus.dg_we;
            end
            default: ;
        endcase
    end

`ifdef RAM_BUS_ARBITER_WINDOW_EN
    logic              win_found;
    logic [ADDR_W-1:0] w_lo, w_hi;

    // Lowest-index hit wins; an empty or inverted window can never satisfy lo <= a < hi.
    always_comb begin
        win_we    = '0;
        win_off   = '0;
        win_found = 1'b0;
        w_lo      = '0;
        w_hi      = '0;
        for (int k = 0; k < NUM_WIN; k++) begin
            w_lo = win_start[k*ADDR_W +: ADDR_W];
            w_hi = win_end[k*ADDR_W +: ADDR_W];
            if (!win_found && (bus.ram_addr >= w_lo) && (bus.ram_addr < w_hi)) begin
                win_found  = 1'b1;
                win_we[k]  = bus.ram_we & bus.ram_cs;
                win_off    = bus.ram_addr - w_lo;
            end
        end
    end
`else
    logic unused_win;
    assign unused_win = ^{win_start, win_end};
    assign win_we     = '0;
    assign win_off    = '0;
`endif
endmodule
